mips_cpu_hilo_unit: RTL and testbench

//  HI/LO register unit for the execute stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO,

---
 rtl/mips_cpu_hilo_unit.sv | 105 ++++++++++
 tb/tb_mips_cpu_hilo_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_hilo_unit.sv
// mips_cpu_hilo_unit: HI/LO register unit handling multiply, divide sequencing and MTHI/MTLO writes
module mips_cpu_hilo_unit #(
  parameter bit DBZ_WRITES_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbz,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done
);
  typedef enum logic [2:0] {IDLE, MUL, DIV_ISSUE, DIV_WAIT, DIV_FIX} state_t;
  state_t state;
  logic [31:0] op_a, op_b, q_r, r_r, mag_rs, mag_rt;
  logic mul_signed, sign_q, sign_r, is_sdiv;
  logic signed [63:0] ea, eb;
  logic [63:0] prod;
  assign busy = state != IDLE;
  assign div_start = state == DIV_ISSUE;
  assign div_dividend = op_a;
  assign div_divisor = op_b;
  assign is_sdiv = op == 3'd2;
  assign mag_rs = (is_sdiv && rs_val[31]) ? 32'd0 - rs_val : rs_val;
  assign mag_rt = (is_sdiv && rt_val[31]) ? 32'd0 - rt_val : rt_val;
  // Sign-extend only for MULT; the low 64 bits of the product are then right for both forms
  assign ea = {{32{mul_signed & op_a[31]}}, op_a};
  assign eb = {{32{mul_signed & op_b[31]}}, op_b};
  assign prod = 64'(ea * eb);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      dbz <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      q_r <= '0;
      r_r <= '0;
      mul_signed <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      dbz <= 1'b0;
      case (state)
        IDLE: if (op_valid) begin
          case (op)
            3'd0, 3'd1: begin
              op_a <= rs_val;
              op_b <= rt_val;
              mul_signed <= op == 3'd0;
              state <= MUL;
            end
            3'd2, 3'd3: begin
              if (rt_val == '0) begin
                dbz <= 1'b1;
                if (DBZ_WRITES_ZERO) begin
                  hi <= '0;
                  lo <= '0;
                end
              end else if (rs_val == '0) begin
                hi <= '0;
                lo <= '0;
              end else begin
                op_a <= mag_rs;
                op_b <= mag_rt;
                sign_q <= is_sdiv & (rs_val[31] ^ rt_val[31]);
                sign_r <= is_sdiv & rs_val[31];
                state <= DIV_ISSUE;
              end
            end
            3'd4: hi <= rs_val;
            3'd5: lo <= rs_val;
            default: ;
          endcase
        end
        MUL: begin
          {hi, lo} <= prod;
          state <= IDLE;
        end
        DIV_ISSUE: state <= DIV_WAIT;
        DIV_WAIT: if (div_done) begin
          q_r <= div_quotient;
          r_r <= div_remainder;
          state <= DIV_FIX;
        end
        DIV_FIX: begin
          lo <= sign_q ? 32'd0 - q_r : q_r;
          hi <= sign_r ? 32'd0 - r_r : r_r;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// tb_mips_cpu_hilo_unit: directed bench with a behavioural multi-cycle divider
module tb_mips_cpu_hilo_unit;
  logic clk = 0, reset = 1, op_valid = 0;
  logic [2:0] op = 0;
  logic [31:0] rs_val = 0, rt_val = 0;
  logic busy, dbz, div_start, div_done;
  logic [31:0] hi, lo, div_dividend, div_divisor, div_quotient, div_remainder;
  int tests = 0, fails = 0, starts = 0, dcnt = 0;

  mips_cpu_hilo_unit dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .hi(hi), .lo(lo), .dbz(dbz), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      div_done <= 0;
      dcnt <= 0;
      div_quotient <= 0;
      div_remainder <= 0;
    end else if (div_start) begin
      starts <= starts + 1;
      div_done <= 0;
      dcnt <= 3;
      div_quotient <= div_dividend / div_divisor;
      div_remainder <= div_dividend % div_divisor;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) div_done <= 1;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    op_valid = 0; op = 3'd7;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL %s timeout: busy=%b required 0", name, busy); end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, dbz, div_start, hi, lo} !== 67'd0) begin
      fails++; $display("FAIL reset: busy=%b dbz=%b start=%b hi=%h lo=%h required all 0", busy, dbz, div_start, hi, lo);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo;
    issue(3'd4, 32'h1234, 0);
    issue(3'd5, 32'h1234, 0);
    tests++;
    if (hi !== 32'h1234 || lo !== 32'h1234 || busy !== 0) begin
      fails++; $display("FAIL mthi_mtlo: hi=%h lo=%h busy=%b required 1234 1234 0", hi, lo, busy);
    end
  endtask

  task automatic test_mult;
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    tests++;
    if (busy !== 1 || hi !== 32'h1234) begin fails++; $display("FAIL mult_busy: busy=%b hi=%h required 1 1234", busy, hi); end
    @(negedge clk);
    tests++;
    if (busy !== 0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      fails++; $display("FAIL mult: busy=%b hi=%h lo=%h required 0 ffffffff fffffff1", busy, hi, lo);
    end
  endtask

  task automatic test_multu;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    tests++;
    if (busy !== 0 || hi !== 32'hFFFFFFFE || lo !== 32'h1) begin
      fails++; $display("FAIL multu: busy=%b hi=%h lo=%h required 0 fffffffe 00000001", busy, hi, lo);
    end
  endtask

  task automatic test_divu;
    int s0 = starts;
    issue(3'd3, 32'd100, 32'd7);
    tests++;
    if (busy !== 1 || div_start !== 1 || div_dividend !== 32'd100 || div_divisor !== 32'd7) begin
      fails++; $display("FAIL divu_issue: busy=%b start=%b dd=%0d dv=%0d required 1 1 100 7", busy, div_start, div_dividend, div_divisor);
    end
    @(negedge clk);
    tests++;
    if (div_start !== 0 || busy !== 1) begin fails++; $display("FAIL divu_wait: start=%b busy=%b required 0 1", div_start, busy); end
    wait_idle("divu");
    tests++;
    if (starts - s0 != 1 || lo !== 32'd14 || hi !== 32'd2) begin
      fails++; $display("FAIL divu: starts=%0d lo=%0d hi=%0d required 1 14 2", starts - s0, lo, hi);
    end
  endtask

  task automatic test_div_signed;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    tests++;
    if (div_dividend !== 32'd7 || div_divisor !== 32'd2) begin
      fails++; $display("FAIL div_mag: dd=%h dv=%h required 7 2", div_dividend, div_divisor);
    end
    wait_idle("div_signed");
    tests++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL div_signed: lo=%h hi=%h required fffffffd ffffffff", lo, hi);
    end
  endtask

  task automatic test_dbz;
    int s0;
    issue(3'd4, 32'h1234, 0);
    issue(3'd5, 32'h1234, 0);
    s0 = starts;
    issue(3'd2, 32'd5, 32'd0);
    tests++;
    if (dbz !== 1 || busy !== 0 || div_start !== 0) begin
      fails++; $display("FAIL dbz_pulse: dbz=%b busy=%b start=%b required 1 0 0", dbz, busy, div_start);
    end
    @(negedge clk);
    tests++;
    if (dbz !== 0 || starts != s0 || hi !== 32'h1234 || lo !== 32'h1234) begin
      fails++; $display("FAIL dbz_after: dbz=%b starts=%0d hi=%h lo=%h required 0 0 1234 1234", dbz, starts - s0, hi, lo);
    end
  endtask

  task automatic test_div_zero_dividend;
    int s0 = starts;
    issue(3'd2, 32'd0, 32'd9);
    tests++;
    if (busy !== 0 || hi !== 0 || lo !== 0 || dbz !== 0) begin
      fails++; $display("FAIL div_zero_rs: busy=%b hi=%h lo=%h dbz=%b required 0 0 0 0", busy, hi, lo, dbz);
    end
    @(negedge clk);
    tests++;
    if (starts != s0) begin fails++; $display("FAIL div_zero_rs_start: starts=%0d required 0", starts - s0); end
  endtask

  task automatic test_overflow_ignore;
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    tests++;
    if (busy !== 1 || div_dividend !== 32'h80000000 || div_divisor !== 32'd1) begin
      fails++; $display("FAIL ovf_issue: busy=%b dd=%h dv=%h required 1 80000000 1", busy, div_dividend, div_divisor);
    end
    issue(3'd5, 32'hDEAD, 0);
    wait_idle("ovf");
    tests++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      fails++; $display("FAIL ovf: lo=%h hi=%h required 80000000 00000000", lo, hi);
    end
    @(negedge clk);
    tests++;
    if (lo !== 32'h80000000) begin fails++; $display("FAIL busy_ignore: lo=%h required 80000000", lo); end
  endtask

  task automatic test_reset_mid;
    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    tests++;
    if (busy !== 0 || hi !== 0 || lo !== 0 || div_start !== 0) begin
      fails++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h start=%b required 0 0 0 0", busy, hi, lo, div_start);
    end
    reset = 0;
    @(negedge clk);
    issue(3'd0, 32'd3, 32'd4);
    @(negedge clk);
    tests++;
    if (busy !== 0 || lo !== 32'd12 || hi !== 32'd0) begin
      fails++; $display("FAIL mult_after_reset: busy=%b lo=%h hi=%h required 0 0000000c 00000000", busy, lo, hi);
    end
  endtask

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_mult;
    test_multu;
    test_divu;
    test_div_signed;
    test_dbz;
    test_div_zero_dividend;
    test_overflow_ignore;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
